// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out shifter with valid/ready load handshake.
// Zero-gap back-to-back words: a new word is accepted during the last-bit cycle.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;
    logic             load;

    assign load_ready  = (state == IDLE) || (cnt == '0);
    assign load        = load_valid && load_ready;
    assign busy        = (state == SHIFT);
    assign dout_valid  = busy;
    assign dout        = busy && (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]);
    assign frame_start = busy && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
        end else if (load) begin
            state     <= SHIFT;
            shift_reg <= din;
            cnt       <= CW'(WIDTH - 1);
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                shift_reg <= MSB_FIRST ? {shift_reg[WIDTH-2:0], 1'b0} : {1'b0, shift_reg[WIDTH-1:1]};
                cnt       <= cnt - 1'b1;
            end else begin
                // clear leftovers so IDLE always holds an all-zero register
                state     <= IDLE;
                shift_reg <= '0;
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed self-checking bench for three piso_serializer configurations.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    logic [7:0] a_din = '0;
    logic a_lv = 1'b0, a_lr, a_dout, a_dv, a_fs, a_busy;
    logic [7:0] b_din = '0;
    logic b_lv = 1'b0, b_lr, b_dout, b_dv, b_fs, b_busy;
    logic [1:0] c_din = '0;
    logic c_lv = 1'b0, c_lr, c_dout, c_dv, c_fs, c_busy;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(reset), .din(a_din), .load_valid(a_lv), .load_ready(a_lr),
        .dout(a_dout), .dout_valid(a_dv), .frame_start(a_fs), .busy(a_busy));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(reset), .din(b_din), .load_valid(b_lv), .load_ready(b_lr),
        .dout(b_dout), .dout_valid(b_dv), .frame_start(b_fs), .busy(b_busy));
    piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(reset), .din(c_din), .load_valid(c_lv), .load_ready(c_lr),
        .dout(c_dout), .dout_valid(c_dv), .frame_start(c_fs), .busy(c_busy));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic dout, input logic dv, input logic fs,
                         input logic lr, input logic busy);
        chk({tag, ".dout"}, a_dout, dout);
        chk({tag, ".dv"}, a_dv, dv);
        chk({tag, ".fs"}, a_fs, fs);
        chk({tag, ".lr"}, a_lr, lr);
        chk({tag, ".busy"}, a_busy, busy);
    endtask

    initial begin
        logic [7:0] w;
        logic [15:0] bb;
        #1 reset = 1'b0;
        #1 chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("reset.b_lr", b_lr, 1'b1);
        chk("reset.c_lr", c_lr, 1'b1);
        tick();
        tick();
        reset = 1'b1;

        // 0xA5 MSB-first, loaded on the very first edge after reset release
        w = 8'hA5;
        a_lv = 1'b1; a_din = w;
        chk("a5.idle_lr", a_lr, 1'b1);
        tick();
        a_lv = 1'b0; a_din = 8'h00;
        for (int i = 0; i < 8; i++) begin
            chk_a($sformatf("a5.b%0d", i), w[7-i], 1'b1, i == 0, i == 7, 1'b1);
            tick();
        end
        chk_a("a5.after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // back-to-back 0xFF then 0x00 with load_valid held
        bb = 16'hFF00;
        a_lv = 1'b1; a_din = 8'hFF;
        tick();
        a_din = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) a_lv = 1'b0;
            chk_a($sformatf("b2b.b%0d", i), bb[15-i], 1'b1, i == 0 || i == 8, i == 7 || i == 15, 1'b1);
            tick();
        end
        chk("b2b.after_busy", a_busy, 1'b0);

        // load attempt during bit 4 of 0x81 must be ignored
        w = 8'h81;
        a_lv = 1'b1; a_din = w;
        tick();
        a_lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin a_lv = 1'b1; a_din = 8'h3C; end
            if (i == 7) a_lv = 1'b0;
            chk_a($sformatf("x81.b%0d", i), w[7-i], 1'b1, i == 0, i == 7, 1'b1);
            tick();
        end
        chk("x81.after_busy", a_busy, 1'b0);
        chk("x81.after_dv", a_dv, 1'b0);

        // asynchronous reset during bit 3 of 0xF0
        a_lv = 1'b1; a_din = 8'hF0;
        tick();
        a_lv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("f0.b%0d", i), a_dout, 1'b1);
            if (i < 2) tick();
        end
        #2 reset = 1'b0;
        #1 chk_a("f0.async", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 reset = 1'b1;
        tick();
        chk("f0.aborted_busy", a_busy, 1'b0);
        chk("f0.aborted_dv", a_dv, 1'b0);
        w = 8'h0F;
        a_lv = 1'b1; a_din = w;
        tick();
        a_lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_a($sformatf("x0f.b%0d", i), w[7-i], 1'b1, i == 0, i == 7, 1'b1);
            tick();
        end

        // LSB-first 0x01
        w = 8'h01;
        b_lv = 1'b1; b_din = w;
        tick();
        b_lv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb.dout%0d", i), b_dout, w[i]);
            chk($sformatf("lsb.fs%0d", i), b_fs, i == 0);
            tick();
        end
        chk("lsb.after_busy", b_busy, 1'b0);

        // WIDTH=2 continuous stream of 2'b10
        c_lv = 1'b1; c_din = 2'b10;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w2.dout%0d", i), c_dout, i % 2 == 0);
            chk($sformatf("w2.fs%0d", i), c_fs, i % 2 == 0);
            chk($sformatf("w2.dv%0d", i), c_dv, 1'b1);
            chk($sformatf("w2.lr%0d", i), c_lr, i % 2 == 1);
            if (i == 3) c_lv = 1'b0;
            tick();
        end
        chk("w2.after_busy", c_busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
